// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the RV32I execute/memory stage and a
// handshaked data memory.
//
// One access runs at a time: IDLE -> REQ -> DONE, or IDLE -> ERR when the
// address is misaligned, or REQ -> ERR when the memory does not acknowledge
// within TIMEOUT request cycles. Stores get byte enables and lane-replicated
// write data. Loads get their bytes extracted and sign- or zero-extended.
//
// Parameters
//   TIMEOUT     max cycles mem_req stays high without mem_ack (1..255)
// Ports
//   CLK, Reset_n                  clock, asynchronous active-low reset
//   MemR, MemW                    load / store request from the decoder
//   Load_size                     0 word, 1 half, 2 byte, 3 treated as word
//   Unsigned                      zero-extend loads
//   Addr, WriteData               byte address, store source (rs2)
//   Stall                         holds PC and pipeline registers
//   ReadData                      extended load result, registered
//   Done, Misaligned, Bus_err     one-cycle completion / error pulses
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata             memory request, held stable during REQ
//   mem_ack, mem_rdata            memory acknowledge and read word
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        MemR,
  input  logic        MemW,
  input  logic [1:0]  Load_size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Misaligned,
  output logic        Bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  // Count value seen in the last REQ cycle allowed before abort.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        accept;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        cause_bus_q;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd2:    return 1'b0;
      2'd1:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd2:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd2:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rd);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h  = off[1] ? rd[31:16] : rd[15:0];
    bs = b;
    hs = h;
    case (size)
      2'd2:    return uns ? {24'd0, b} : 32'(bs);
      2'd1:    return uns ? {16'd0, h} : 32'(hs);
      default: return rd;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    Stall      = 1'b0;
    mem_req    = 1'b0;
    Done       = 1'b0;
    Misaligned = 1'b0;
    Bus_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemR || MemW) begin
          Stall = 1'b1;
          if (is_misaligned(Load_size, Addr[1:0])) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            accept  = 1'b1;
          end
        end
      end
      REQ: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        Misaligned = !cause_bus_q;
        Bus_err    = cause_bus_q;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
      cnt_q       <= 8'd0;
      rdata_q     <= 32'd0;
      cause_bus_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Request capture: everything the memory sees is frozen here.
      if (accept) begin
        we_q    <= MemW;
        be_q    <= lane_be(Load_size, Addr[1:0]);
        addr_q  <= {Addr[31:2], 2'b00};
        wdata_q <= lane_wdata(Load_size, WriteData);
        size_q  <= Load_size;
        uns_q   <= Unsigned;
        off_q   <= Addr[1:0];
        cnt_q   <= 8'd0;
      end else if (state_q == IDLE && (MemR || MemW)) begin
        cause_bus_q <= 1'b0;
      end
      // Response capture: load data at ack, or count a wait cycle.
      if (state_q == REQ) begin
        if (mem_ack) begin
          if (!we_q) rdata_q <= extend_load(size_q, uns_q, off_q, mem_rdata);
        end else begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == TO_LAST) cause_bus_q <= 1'b1;
        end
      end
    end
  end

  assign ReadData  = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b1;
  logic        MemR = 1'b0, MemW = 1'b0, Unsigned = 1'b0, mem_ack = 1'b0;
  logic [1:0]  Load_size = 2'd0;
  logic [31:0] Addr = 32'd0, WriteData = 32'd0, mem_rdata = 32'd0;
  logic        Stall, Done, Misaligned, Bus_err, mem_req, mem_we;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_chk = 0;
  int n_ok  = 0;
  logic [31:0] exp_rd;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .MemR(MemR), .MemW(MemW), .Load_size(Load_size),
    .Unsigned(Unsigned), .Addr(Addr), .WriteData(WriteData), .Stall(Stall),
    .ReadData(ReadData), .Done(Done), .Misaligned(Misaligned), .Bus_err(Bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    #2;
    n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_req got %b want 0", mem_req); else n_ok++;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_we got %b want 0", mem_we); else n_ok++;
    n_chk++; if ({Done, Misaligned, Bus_err} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {Done, Misaligned, Bus_err}); else n_ok++;
    n_chk++; if (mem_be !== 4'b0000) $display("FAIL rst_be got %b want 0000", mem_be); else n_ok++;
    n_chk++; if (mem_addr !== 32'd0) $display("FAIL rst_addr got %h want 0", mem_addr); else n_ok++;
    n_chk++; if (mem_wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", mem_wdata); else n_ok++;
    n_chk++; if (ReadData !== 32'd0) $display("FAIL rst_rdata got %h want 0", ReadData); else n_ok++;
    n_chk++; if (Stall !== 1'b0) $display("FAIL rst_stall_idle got %b want 0", Stall); else n_ok++;
    MemR = 1'b1;
    #1;
    n_chk++; if (Stall !== 1'b1) $display("FAIL rst_stall_req got %b want 1", Stall); else n_ok++;
    MemR = 1'b0;
    step();
    step();
    Reset_n = 1'b1;
    step();
    n_chk++; if (Stall !== 1'b0 || Done !== 1'b0) $display("FAIL post_rst got stall=%b done=%b want 0 0", Stall, Done); else n_ok++;
    exp_rd = 32'd0;
  endtask

  task automatic test_lb();
    MemR = 1'b1; Load_size = 2'd2; Unsigned = 1'b0; Addr = 32'h103;
    #1;
    n_chk++; if (Stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL lb_c0 got stall=%b req=%b want 1 0", Stall, mem_req); else n_ok++;
    step();
    n_chk++; if (mem_req !== 1'b1 || Stall !== 1'b1) $display("FAIL lb_c1 got req=%b stall=%b want 1 1", mem_req, Stall); else n_ok++;
    n_chk++; if (mem_be !== 4'b1000) $display("FAIL lb_be got %b want 1000", mem_be); else n_ok++;
    n_chk++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) $display("FAIL lb_addr got %h we=%b want 00000100 0", mem_addr, mem_we); else n_ok++;
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    step();
    mem_ack = 1'b0; MemR = 1'b0;
    #1;
    exp_rd = 32'hFFFF_FF80;
    n_chk++; if (Done !== 1'b1 || Stall !== 1'b0) $display("FAIL lb_c2 got done=%b stall=%b want 1 0", Done, Stall); else n_ok++;
    n_chk++; if (ReadData !== exp_rd) $display("FAIL lb_rdata got %h want %h", ReadData, exp_rd); else n_ok++;
    step();
    n_chk++; if (Done !== 1'b0 || mem_req !== 1'b0) $display("FAIL lb_c3 got done=%b req=%b want 0 0", Done, mem_req); else n_ok++;
  endtask

  task automatic test_lh();
    logic [31:0] want [2] = '{32'h0000_9ABC, 32'hFFFF_9ABC};
    for (int k = 0; k < 2; k++) begin
      MemR = 1'b1; Load_size = 2'd1; Unsigned = (k == 0); Addr = 32'h102;
      step();
      n_chk++; if (mem_be !== 4'b1100) $display("FAIL lh%0d_be got %b want 1100", k, mem_be); else n_ok++;
      mem_ack = 1'b1; mem_rdata = 32'h9ABC_5678;
      step();
      mem_ack = 1'b0; MemR = 1'b0; Unsigned = 1'b0;
      #1;
      exp_rd = want[k];
      n_chk++; if (Done !== 1'b1 || ReadData !== exp_rd) $display("FAIL lh%0d_rdata got done=%b %h want 1 %h", k, Done, ReadData, exp_rd); else n_ok++;
      step();
    end
  endtask

  task automatic test_sb_wait();
    int stalls = 0;
    MemW = 1'b1; Load_size = 2'd2; Addr = 32'h201; WriteData = 32'h1234_56A5;
    #1;
    if (Stall === 1'b1) stalls++;
    step();
    Addr = 32'hFFF; WriteData = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      if (Stall === 1'b1) stalls++;
      n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL sb_req%0d got req=%b we=%b want 1 1", i, mem_req, mem_we); else n_ok++;
      n_chk++; if (mem_be !== 4'b0010 || mem_addr !== 32'h200) $display("FAIL sb_lane%0d got be=%b addr=%h want 0010 00000200", i, mem_be, mem_addr); else n_ok++;
      n_chk++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata%0d got %h want a5a5a5a5", i, mem_wdata); else n_ok++;
      n_chk++; if (Done !== 1'b0) $display("FAIL sb_early_done%0d got %b want 0", i, Done); else n_ok++;
      if (i == 4) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
      end
      step();
    end
    mem_ack = 1'b0; MemW = 1'b0;
    #1;
    if (Stall === 1'b1) stalls++;
    n_chk++; if (Done !== 1'b1 || Stall !== 1'b0) $display("FAIL sb_done got done=%b stall=%b want 1 0", Done, Stall); else n_ok++;
    n_chk++; if (stalls !== 5) $display("FAIL sb_stall_cycles got %0d want 5", stalls); else n_ok++;
    n_chk++; if (ReadData !== exp_rd) $display("FAIL sb_rdata_kept got %h want %h", ReadData, exp_rd); else n_ok++;
    step();
  endtask

  task automatic test_misaligned();
    logic        v_we   [2] = '{1'b0, 1'b1};
    logic [1:0]  v_size [2] = '{2'd0, 2'd1};
    logic [31:0] v_addr [2] = '{32'h302, 32'h301};
    for (int k = 0; k < 2; k++) begin
      MemR = !v_we[k]; MemW = v_we[k]; Load_size = v_size[k]; Addr = v_addr[k];
      #1;
      n_chk++; if (Stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL mis%0d_c0 got stall=%b req=%b want 1 0", k, Stall, mem_req); else n_ok++;
      step();
      MemR = 1'b0; MemW = 1'b0;
      #1;
      n_chk++; if (Misaligned !== 1'b1 || Bus_err !== 1'b0) $display("FAIL mis%0d_pulse got mis=%b berr=%b want 1 0", k, Misaligned, Bus_err); else n_ok++;
      n_chk++; if (Stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL mis%0d_c1 got stall=%b req=%b want 0 0", k, Stall, mem_req); else n_ok++;
      n_chk++; if (ReadData !== exp_rd) $display("FAIL mis%0d_rdata got %h want %h", k, ReadData, exp_rd); else n_ok++;
      step();
      n_chk++; if (Misaligned !== 1'b0 || mem_req !== 1'b0) $display("FAIL mis%0d_c2 got mis=%b req=%b want 0 0", k, Misaligned, mem_req); else n_ok++;
    end
  endtask

  task automatic test_store_lanes();
    logic [1:0]  v_size  [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] v_addr  [3] = '{32'h700, 32'h702, 32'h700};
    logic [31:0] v_data  [3] = '{32'h1122_3344, 32'hCAFE_BEEF, 32'h0000_005A};
    logic [3:0]  w_be    [3] = '{4'b1111, 4'b1100, 4'b0001};
    logic [31:0] w_wdata [3] = '{32'h1122_3344, 32'hBEEF_BEEF, 32'h5A5A_5A5A};
    for (int k = 0; k < 3; k++) begin
      MemR = 1'b1; MemW = 1'b1; Load_size = v_size[k]; Addr = v_addr[k]; WriteData = v_data[k];
      step();
      n_chk++; if (mem_we !== 1'b1) $display("FAIL st%0d_we got %b want 1", k, mem_we); else n_ok++;
      n_chk++; if (mem_be !== w_be[k] || mem_wdata !== w_wdata[k]) $display("FAIL st%0d_lane got be=%b wdata=%h want %b %h", k, mem_be, mem_wdata, w_be[k], w_wdata[k]); else n_ok++;
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      step();
      mem_ack = 1'b0; MemR = 1'b0; MemW = 1'b0;
      #1;
      n_chk++; if (Done !== 1'b1 || ReadData !== exp_rd) $display("FAIL st%0d_done got done=%b rdata=%h want 1 %h", k, Done, ReadData, exp_rd); else n_ok++;
      step();
    end
  endtask

  task automatic test_timeout();
    for (int p = 0; p < 2; p++) begin
      MemR = 1'b1; Load_size = 2'd0; Addr = 32'h500;
      step();
      for (int i = 1; i <= 4; i++) begin
        n_chk++; if (mem_req !== 1'b1) $display("FAIL to%0d_req%0d got %b want 1", p, i, mem_req); else n_ok++;
        if (p == 1 && i == 4) begin
          mem_ack = 1'b1;
          mem_rdata = 32'h0BAD_F00D;
        end
        step();
      end
      mem_ack = 1'b0; MemR = 1'b0;
      #1;
      if (p == 1) exp_rd = 32'h0BAD_F00D;
      n_chk++; if (mem_req !== 1'b0 || Stall !== 1'b0) $display("FAIL to%0d_end got req=%b stall=%b want 0 0", p, mem_req, Stall); else n_ok++;
      n_chk++; if (Bus_err !== (p == 0) || Done !== (p == 1)) $display("FAIL to%0d_pulse got berr=%b done=%b want %b %b", p, Bus_err, Done, p == 0, p == 1); else n_ok++;
      n_chk++; if (Misaligned !== 1'b0 || ReadData !== exp_rd) $display("FAIL to%0d_rdata got mis=%b rdata=%h want 0 %h", p, Misaligned, ReadData, exp_rd); else n_ok++;
      step();
      n_chk++; if (Bus_err !== 1'b0 || Done !== 1'b0) $display("FAIL to%0d_after got berr=%b done=%b want 0 0", p, Bus_err, Done); else n_ok++;
    end
  endtask

  task automatic test_reset_mid_req();
    MemR = 1'b1; Load_size = 2'd0; Addr = 32'h600;
    step();
    step();
    n_chk++; if (mem_req !== 1'b1) $display("FAIL mid_wait_req got %b want 1", mem_req); else n_ok++;
    MemR = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0 || Stall !== 1'b0) $display("FAIL mid_rst got req=%b stall=%b want 0 0", mem_req, Stall); else n_ok++;
    n_chk++; if (ReadData !== 32'd0) $display("FAIL mid_rst_rdata got %h want 0", ReadData); else n_ok++;
    step();
    Reset_n = 1'b1;
    mem_ack = 1'b1;
    step();
    n_chk++; if (Done !== 1'b0 || mem_req !== 1'b0) $display("FAIL idle_ack got done=%b req=%b want 0 0", Done, mem_req); else n_ok++;
    mem_ack = 1'b0;
    MemR = 1'b1; Addr = 32'h400;
    step();
    n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_be !== 4'b1111) $display("FAIL lw400_req got req=%b addr=%h be=%b want 1 00000400 1111", mem_req, mem_addr, mem_be); else n_ok++;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; MemR = 1'b0;
    #1;
    n_chk++; if (Done !== 1'b1 || ReadData !== 32'hDEAD_BEEF) $display("FAIL lw400_done got done=%b rdata=%h want 1 deadbeef", Done, ReadData); else n_ok++;
    step();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lh();
    test_sb_wait();
    test_misaligned();
    test_store_lanes();
    test_timeout();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the RV32I core's execute/memory stage and a handshaked data memory. It takes the load/store controls produced by the instruction decoder plus the ALU-computed address, and issues a single `mem_req`/`mem_ack` transaction. It generates byte enables and replicated write data, extracts and sign- or zero-extends load data, and stalls the pipeline until the access completes. Misaligned accesses and memory timeouts are flagged as single-cycle error pulses instead of being issued.

## Interface
- `TIMEOUT`, 255: maximum cycles `mem_req` stays high without `mem_ack` before the access is aborted (1..255).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `MemR` in 1: load requested (decoder MemtoReg).
- `MemW` in 1: store requested (decoder MemW).
- `Load_size` in 2: 0 = word, 1 = half, 2 = byte, 3 = reserved (treated as word).
- `Unsigned` in 1: zero-extend the load (decoder ImmSrc[3]); ignored for stores.
- `Addr` in 32: byte address from the ALU.
- `WriteData` in 32: store source (rs2).
- `Stall` out 1: holds PC and pipeline registers while high.
- `ReadData` out 32: extended load result, registered.
- `Done` out 1: one-cycle pulse when the access completes.
- `Misaligned` out 1: one-cycle pulse for a rejected misaligned access.
- `Bus_err` out 1: one-cycle pulse on timeout.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{Addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory accepted/completed the access this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ack`=1.

## Operation
- States: IDLE, REQ, DONE, ERR.
- **IDLE**
  - With `MemR` or `MemW` high:
    - If misaligned (half with `Addr[0]`=1, or word with `Addr[1:0]`≠0), go to ERR.
    - Otherwise latch the operation, address, size, Unsigned and data, then go to REQ.
  - If both `MemR` and `MemW` are high, the store wins.
- **REQ**
  - `mem_req`=1 and all `mem_*` outputs are driven from latched values, stable until acknowledged.
  - On `mem_ack`=1: for a load, capture the extended data into `ReadData`; go to DONE.
  - On timeout, go to ERR.
- **DONE**: `Done`=1, `Stall`=0, then go to IDLE.
- **ERR**: `Stall`=0; pulse `Misaligned` or `Bus_err` according to cause; go to IDLE. `ReadData` is unchanged.
- `Stall` = (IDLE and (`MemR` or `MemW`)) or REQ. This is combinational, so the requesting instruction is held from its first cycle.
- Byte lanes (`o` = `Addr[1:0]`):
  - Byte: `mem_be` = 1<<`o`, `mem_wdata` = {4{WriteData[7:0]}}.
  - Half: `mem_be` = 0011 when `o[1]`=0, 1100 otherwise; `mem_wdata` = {2{WriteData[15:0]}}.
  - Word: `mem_be` = 1111, `mem_wdata` = WriteData.
  - Loads drive `mem_be` with the same pattern and `mem_we`=0.
- Load extraction:
  - Byte = `mem_rdata[8o+7:8o]`; half = `mem_rdata[16·o[1]+15:16·o[1]]`.
  - Extend with bit 7 or bit 15, or with zeros if `Unsigned`.
  - Word is passed through; `Unsigned` has no effect.
- Timeout counter: 8-bit, cleared on entry to REQ, increments each REQ cycle without ack. It aborts when it reaches `TIMEOUT` without ack. An ack in the same cycle the count reaches `TIMEOUT` takes priority (DONE).

## Timing
- Reset (async assert): state IDLE; `mem_req`, `mem_we`, `Done`, `Misaligned`, `Bus_err` = 0; `mem_be`=0; `mem_addr`, `mem_wdata`, `ReadData`=0; counter=0. `Stall` then follows its combinational equation.
- Reset asserted mid-access drops `mem_req` immediately, and the access is abandoned. The memory must tolerate a withdrawn request.
- Minimum latency with zero-wait memory:
  - Request seen in cycle 0 (IDLE, Stall=1).
  - Cycle 1: REQ, `mem_req`=1, `mem_ack`=1.
  - Cycle 2: DONE, `Done`=1, `ReadData` valid, Stall=0.
  - Total: 3 cycles, 2 stalled.
- Each wait cycle without ack adds 1 cycle.
- Misaligned: cycle 0 IDLE (Stall=1); cycle 1 ERR (`Misaligned`=1, Stall=0). No `mem_req` is ever issued.
- `mem_ack` is ignored outside REQ.
- `ReadData` holds its value until the next successful load.

## Test plan
- LB: `Addr`=0x103, `Unsigned`=0, `mem_rdata`=0x80FF_1234, ack on first REQ cycle -> `mem_be`=1000, `ReadData`=0xFFFF_FF80, `Done` in cycle 2, Stall high for cycles 0-1 only.
- LHU: `Addr`=0x102, `mem_rdata`=0x9ABC_5678 -> `mem_be`=1100, `ReadData`=0x0000_9ABC. Same with LH -> 0xFFFF_9ABC.
- SB: `Addr`=0x201, `WriteData`=0x1234_56A5, ack after 3 wait cycles -> `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xA5A5_A5A5, `mem_addr`=0x200, all held for 4 REQ cycles, Stall high for 5 cycles.
- LW at `Addr`=0x302 and SH at `Addr`=0x301 -> `Misaligned` pulse, no `mem_req`, Stall high exactly 1 cycle, `ReadData` unchanged.
- Timeout: `TIMEOUT`=4, never ack -> `mem_req` high for exactly 4 cycles, then `Bus_err` pulse, Stall=0. Repeat with ack on the 4th REQ cycle -> `Done`, no `Bus_err`.
- Reset mid-REQ: deassert `Reset_n` during a wait state -> `mem_req`=0 without waiting for a clock edge. After release, state is IDLE and a new LW at 0x400 completes normally.
